div_sequencer: RTL
==================

Name: div_sequencer

Overview:
- Controls the multi-cycle divider for the EX stage.
- Detects DIV/DIVU in EX, latches the operands and launches the external divider with a start/ready handshake.
- Stalls the front of the pipeline until the result is back, holds the result until EX can advance, then drives the HI/LO write.
- Cancels the operation cleanly on an EX flush and guards against a hung divider with a watchdog counter.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W bits ({rem,quot} = {HI,LO}).
- TIMEOUT, 48, maximum RUN cycles before the operation is aborted (must exceed divider latency).
- CNT_W, 6, watchdog counter width; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- alucontrolE  in  5  EX ALU control; compared against DIV_CONTROL / DIVU_CONTROL
- hilowriteE  in  2  HI/LO write enables from decode, passed through for non-div ops
- srcaE  in  DATA_W  dividend
- srcbE  in  DATA_W  divisor
- flushE  in  1  EX flush (exception/branch); kills the in-flight div
- stallE  in  1  external EX stall from later stages; EX instruction is not advancing
- div_start  out  1  divider start, level, held through RUN
- div_signed  out  1  1 = DIV, 0 = DIVU (latched)
- div_opa  out  DATA_W  latched dividend
- div_opb  out  DATA_W  latched divisor
- div_annul  out  1  one-cycle abort pulse to the divider
- div_result  in  2*DATA_W  {remainder, quotient}
- div_ready  in  1  divider result valid
- stall_div  out  1  freeze IF/ID/EX
- hilowrite2E  out  2  final HI/LO write enables
- hilo_wdata  out  2*DATA_W  {HI,LO} write data
- div_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Definition: is_div = (alucontrolE == DIV_CONTROL or DIVU_CONTROL).
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: all registered outputs 0, counter 0, result register 0.
- IDLE:
  - If is_div and !flushE: latch srcaE/srcbE/signedness, clear counter, go to RUN.
  - stall_div = is_div and !flushE (combinational), so the div stays in EX.
- RUN:
  - div_start=1; counter increments every cycle; stall_div=1 unless flushE.
  - Priority: flushE > div_ready > timeout.
  - flushE: div_annul=1 for that cycle, go to IDLE; div_ready in the same cycle is ignored.
  - div_ready: capture div_result into the result register, go to DONE (first cycle of DONE is result-visible, one-cycle latency).
  - counter == TIMEOUT-1 without ready: div_annul=1, div_timeout=1, result register := 0, go to DONE.
- DONE:
  - stall_div=0; hilowrite2E=2'b11; hilo_wdata = result register.
  - If stallE: stay in DONE, outputs held stable.
  - Else (the instruction advances this edge): go to IDLE.
  - flushE: go to IDLE, hilowrite2E=2'b00 that cycle.
- Output rules outside DONE:
  - is_div: hilowrite2E=2'b00 in IDLE and RUN.
  - Non-div op: hilowrite2E = hilowriteE; hilo_wdata = 0; stall_div = 0.
- Back-to-back divs: the second div seen in IDLE the cycle after DONE exits starts normally (no bubble beyond the IDLE cycle).
- div_opa/div_opb/div_signed are stable for the whole of RUN, independent of srcaE/srcbE changes.
- rst in any state: return to IDLE next edge; div_annul not required (divider is reset by the same rst).

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- With it, in IDLE:
  - An is_div request with srcbE == 0 skips the divider and goes directly to DONE, with no div_start asserted.
  - Result = {srcaE, all-ones} (HI=dividend, LO=0xFFFFFFFF), for both signed and unsigned.
  - The request still costs 1 stall cycle.
- Without it, zero divisors go to the divider like any other operand.

Decomposition:
- Shared package/defines: DIV_CONTROL, DIVU_CONTROL codes, FSM state encoding (2-bit), HILO_WR_BOTH=2'b11, HILO_WR_NONE=2'b00.
- One natural sub-module: div_watchdog (counter with clear/enable, expiry flag at TIMEOUT-1).
- The FSM and result register stay in div_sequencer.

Test Plan:
- DIV 100/7, divider ready after 36 RUN cycles, stallE=0 -> stall_div high in the request cycle plus 36 RUN cycles; DONE shows hilo_wdata={0x2,0xE}, hilowrite2E=11 for 1 cycle; IDLE next.
- DIVU 0xFFFFFFFF/2 with stallE=1 for 3 cycles in DONE -> DONE held 4 cycles, hilo_wdata={0x1,0x7FFFFFFF} stable, single exit to IDLE.
- flushE asserted at RUN cycle 10 -> div_annul pulse that cycle, stall_div=0, IDLE next; a div_ready on cycle 11 produces no HI/LO write.
- Divider never asserts ready -> at RUN cycle 48, div_timeout=1 and div_annul=1; DONE with hilo_wdata=0; pipeline resumes.
- Non-div op with hilowriteE=2'b10 (MTHI) -> hilowrite2E=2'b10, stall_div=0, FSM remains IDLE.
- DIV_ZERO_BYPASS_EN defined: DIV 5/0 -> no div_start; next cycle DONE with hilo_wdata={0x5,0xFFFFFFFF}. Undefined: div_start asserted normally.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// div_sequencer_pkg
// Shared definitions for the EX-stage divider sequencer:
//   - ALU control codes that select the multi-cycle divider (DIV / DIVU)
//   - HI/LO write-enable encodings
//   - 2-bit FSM state encoding used by div_sequencer
//   - is_div_op() helper used by the sequencer and by anything that needs to
//     recognise a divide in EX
// -----------------------------------------------------------------------------
package div_sequencer_pkg;

    // ALU control codes routed to the multi-cycle divider.
    localparam logic [4:0] DIV_CONTROL  = 5'b11010;
    localparam logic [4:0] DIVU_CONTROL = 5'b11011;

    // HI/LO write enables: bit 1 = HI, bit 0 = LO.
    localparam logic [1:0] HILO_WR_BOTH = 2'b11;
    localparam logic [1:0] HILO_WR_NONE = 2'b00;

    // Sequencer state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    // True when the EX ALU control selects a signed or unsigned divide.
    function automatic logic is_div_op(input logic [4:0] ctrl);
        return (ctrl == DIV_CONTROL) || (ctrl == DIVU_CONTROL);
    endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// -----------------------------------------------------------------------------
// div_sequencer_if
// Start/ready handshake bundle between the divider sequencer and the external
// multi-cycle divider.
//   div_start   sequencer -> divider  level start, held for the whole run
//   div_signed  sequencer -> divider  1 = DIV, 0 = DIVU
//   div_opa     sequencer -> divider  latched dividend
//   div_opb     sequencer -> divider  latched divisor
//   div_annul   sequencer -> divider  one-cycle abort pulse
//   div_result  divider -> sequencer  {remainder, quotient}
//   div_ready   divider -> sequencer  result valid
// Modports: master = sequencer side, slave = divider side.
// -----------------------------------------------------------------------------
interface div_sequencer_if #(
    parameter int DATA_W = 32
);

    logic                div_start;
    logic                div_signed;
    logic [DATA_W-1:0]   div_opa;
    logic [DATA_W-1:0]   div_opb;
    logic                div_annul;
    logic [2*DATA_W-1:0] div_result;
    logic                div_ready;

    modport master (
        output div_start,
        output div_signed,
        output div_opa,
        output div_opb,
        output div_annul,
        input  div_result,
        input  div_ready
    );

    modport slave (
        input  div_start,
        input  div_signed,
        input  div_opa,
        input  div_opb,
        input  div_annul,
        output div_result,
        output div_ready
    );

endinterface

// File: rtl/div_watchdog.sv
// -----------------------------------------------------------------------------
// div_watchdog
// Run-length counter guarding against a divider that never answers.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   clr      in   restart the count from zero (takes priority over en)
//   en       in   count one cycle
//   expired  out  count has reached TIMEOUT-1 (combinational from the count)
// Parameters:
//   TIMEOUT  number of counted cycles before expiry
//   CNT_W    counter width, 2**CNT_W must exceed TIMEOUT
// -----------------------------------------------------------------------------
module div_watchdog #(
    parameter int TIMEOUT = 48,
    parameter int CNT_W   = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Run-length counter: cleared on a new launch, advanced while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The expiry cycle is the TIMEOUT-th counted cycle (count starts at 0).
    assign expired = (cnt_r == LAST_CNT);

endmodule

// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
// EX-stage controller for the external multi-cycle divider. Detects DIV/DIVU
// in EX, latches the operands, runs the start/ready handshake, stalls the
// front of the pipeline while the divider works, holds the result until EX can
// advance and then drives the HI/LO write. An EX flush cancels the operation
// (with an annul pulse to the divider) and a watchdog aborts a run that takes
// TIMEOUT cycles without a ready.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   alucontrolE  in   EX ALU control (DIV_CONTROL / DIVU_CONTROL select us)
//   hilowriteE   in   HI/LO write enables from decode (non-div passthrough)
//   srcaE        in   dividend
//   srcbE        in   divisor
//   flushE       in   EX flush, kills the in-flight divide
//   stallE       in   EX held by a later stage
//   div_bus      --   divider handshake (master side of div_sequencer_if)
//   stall_div    out  freeze IF/ID/EX
//   hilowrite2E  out  final HI/LO write enables
//   hilo_wdata   out  {HI,LO} write data
//   div_timeout  out  one-cycle pulse when the watchdog aborts a run
//
// Build option:
//   DIV_ZERO_BYPASS_EN  a divide by zero skips the divider and completes from
//                       IDLE straight to DONE with {dividend, all-ones}.
// -----------------------------------------------------------------------------
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 48,
    parameter int CNT_W   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            alucontrolE,
    input  logic [1:0]            hilowriteE,
    input  logic [DATA_W-1:0]     srcaE,
    input  logic [DATA_W-1:0]     srcbE,
    input  logic                  flushE,
    input  logic                  stallE,
    div_sequencer_if.master       div_bus,
    output logic                  stall_div,
    output logic [1:0]            hilowrite2E,
    output logic [2*DATA_W-1:0]   hilo_wdata,
    output logic                  div_timeout
);

    div_state_e          state_r;
    div_state_e          state_next_s;

    logic                is_div_s;
    logic                launch_s;
    logic                zero_div_s;

    logic [DATA_W-1:0]   opa_r;
    logic [DATA_W-1:0]   opb_r;
    logic                signed_r;
    logic [2*DATA_W-1:0] result_r;

    logic                wd_clr_s;
    logic                wd_en_s;
    logic                wd_expired_s;

    logic                div_start_s;
    logic                div_annul_s;

    assign is_div_s = is_div_op(alucontrolE);

    // A divide is accepted only from IDLE and only if it is not being flushed.
    assign launch_s = (state_r == ST_IDLE) && is_div_s && !flushE;

`ifdef DIV_ZERO_BYPASS_EN
    assign zero_div_s = (srcbE == {DATA_W{1'b0}});
`else
    assign zero_div_s = 1'b0;
`endif

    // Watchdog restarts on every launch and counts only RUN cycles.
    assign wd_clr_s = launch_s;
    assign wd_en_s  = (state_r == ST_RUN);

    div_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr_s),
        .en      (wd_en_s),
        .expired (wd_expired_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; in RUN a flush beats ready, and ready beats expiry.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    if (zero_div_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flushE) begin
                    state_next_s = ST_IDLE;
                end else if (div_bus.div_ready) begin
                    state_next_s = ST_DONE;
                end else if (wd_expired_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                // Leaving DONE means the divide retires (or is flushed) this edge.
                if (flushE) begin
                    state_next_s = ST_IDLE;
                end else if (stallE) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Operand latch: captured once at launch so the divider sees stable inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_r    <= {DATA_W{1'b0}};
            opb_r    <= {DATA_W{1'b0}};
            signed_r <= 1'b0;
        end else if (launch_s) begin
            opa_r    <= srcaE;
            opb_r    <= srcbE;
            signed_r <= (alucontrolE == DIV_CONTROL);
        end else begin
            opa_r    <= opa_r;
            opb_r    <= opb_r;
            signed_r <= signed_r;
        end
    end

    // Result register: divider answer, zero on watchdog abort, or bypass value.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= {(2*DATA_W){1'b0}};
        end else if ((state_r == ST_RUN) && !flushE && div_bus.div_ready) begin
            result_r <= div_bus.div_result;
        end else if ((state_r == ST_RUN) && !flushE && wd_expired_s) begin
            result_r <= {(2*DATA_W){1'b0}};
        end else if (launch_s && zero_div_s) begin
            // HI = dividend, LO = all ones, for both DIV and DIVU.
            result_r <= {srcaE, {DATA_W{1'b1}}};
        end else begin
            result_r <= result_r;
        end
    end

    // FSM outputs: handshake, pipeline stall and HI/LO write control.
    always_comb begin
        div_start_s = 1'b0;
        div_annul_s = 1'b0;
        div_timeout = 1'b0;
        stall_div   = 1'b0;
        hilowrite2E = HILO_WR_NONE;
        hilo_wdata  = {(2*DATA_W){1'b0}};
        case (state_r)
            ST_IDLE: begin
                // Holding the div in EX costs the request cycle as a stall.
                stall_div = is_div_s && !flushE;
                if (is_div_s) begin
                    hilowrite2E = HILO_WR_NONE;
                end else begin
                    hilowrite2E = hilowriteE;
                end
            end
            ST_RUN: begin
                div_start_s = 1'b1;
                stall_div   = !flushE;
                if (is_div_s) begin
                    hilowrite2E = HILO_WR_NONE;
                end else begin
                    hilowrite2E = hilowriteE;
                end
                if (flushE) begin
                    div_annul_s = 1'b1;
                end else if (div_bus.div_ready) begin
                    div_annul_s = 1'b0;
                end else if (wd_expired_s) begin
                    div_annul_s = 1'b1;
                    div_timeout = 1'b1;
                end else begin
                    div_annul_s = 1'b0;
                end
            end
            ST_DONE: begin
                hilo_wdata = result_r;
                if (flushE) begin
                    hilowrite2E = HILO_WR_NONE;
                end else begin
                    hilowrite2E = HILO_WR_BOTH;
                end
            end
            default: begin
                hilowrite2E = HILO_WR_NONE;
            end
        endcase
    end

    assign div_bus.div_start  = div_start_s;
    assign div_bus.div_annul  = div_annul_s;
    assign div_bus.div_signed = signed_r;
    assign div_bus.div_opa    = opa_r;
    assign div_bus.div_opb    = opb_r;

endmodule
